// File: rtl/leb128_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : leb128_pkg
//  Description : Shared LEB128 constants, state encoding and byte-packing
//                helper used by the encoder and the instruction-stream decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package leb128_pkg;

  // Widest integer carried by the LEB128 path and its longest encoding.
  localparam int LEB128_DATA_W    = 64;
  localparam int LEB128_MAX_BYTES = 10;

  // Each LEB128 byte carries seven payload bits; bit 7 flags continuation.
  localparam int LEB128_PAYLOAD_W = 7;
  localparam int LEB128_CONT_BIT  = 7;

  // Width of byte-count / byte-index fields (holds 0..10).
  localparam int LEB128_CNT_W     = 4;

  // Stream FSM states, explicitly encoded.
  typedef enum logic [0:0] {
    LEB_IDLE = 1'b0,
    LEB_EMIT = 1'b1
  } leb_state_e;

  // Assemble one wire byte from a payload chunk; the continuation flag is set
  // on every byte except the final one.
  function automatic logic [7:0] leb128_pack_byte(
    input logic                        i_last,
    input logic [LEB128_PAYLOAD_W-1:0] i_chunk
  );
    logic [7:0] v_byte;
    v_byte                  = {1'b0, i_chunk};
    v_byte[LEB128_CONT_BIT] = ~i_last;
    return v_byte;
  endfunction

endpackage : leb128_pkg
`default_nettype wire

// File: rtl/leb128_len_calc.sv
`default_nettype none
// ============================================================================
//  Module      : leb128_len_calc
//  Description : Combinational LEB128 encoded length (1..MAX) of an integer,
//                unsigned or signed. Also usable for offset precomputation.
//  Revision    : 1.0 - initial release
// ============================================================================
module leb128_len_calc
  import leb128_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 4
) (
  input  logic [DATA_W-1:0] i_value,
  input  logic              i_signed,
  output logic [CNT_W-1:0]  o_byte_cnt
);

  // Wide enough to hold DATA_W+1 significant bits.
  localparam int POS_W = $clog2(DATA_W + 2);

  logic             w_sign;
  logic [POS_W-1:0] w_pos;
  logic [POS_W-1:0] w_bits;

  // Significant bits: position of the highest bit that differs from the
  // reference bit (0 for unsigned, the sign for signed), plus a sign bit
  // when signed. A value with no significant bits still takes one byte.
  always_comb begin
    w_sign = i_signed & i_value[DATA_W-1];
    w_pos  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i_value[i] != w_sign) begin
        w_pos = POS_W'(i + 1);
      end
    end
    w_bits = w_pos + (i_signed ? POS_W'(1) : POS_W'(0));
    if (w_bits == '0) begin
      o_byte_cnt = CNT_W'(1);
    end else begin
      o_byte_cnt = CNT_W'((w_bits + POS_W'(LEB128_PAYLOAD_W - 1)) / POS_W'(LEB128_PAYLOAD_W));
    end
  end

endmodule : leb128_len_calc
`default_nettype wire

// File: rtl/leb128_encode_stream.sv
`default_nettype none
// ============================================================================
//  Module      : leb128_encode_stream
//  Description : Sequential ULEB128/SLEB128 encoder. Accepts one 64-bit value
//                per transaction and emits its minimal LEB128 encoding one
//                byte per cycle on a valid/ready byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module leb128_encode_stream
  import leb128_pkg::*;
#(
  parameter  int DATA_W    = 64,
  localparam int MAX_BYTES = (DATA_W + LEB128_PAYLOAD_W - 1) / LEB128_PAYLOAD_W,
  localparam int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] uint_in,
  input  logic              signed_encode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        byte_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic [CNT_W-1:0]  byte_idx
);

  localparam int PW = LEB128_PAYLOAD_W;

  leb_state_e        r_state;
  leb_state_e        w_state_nxt;
  logic [DATA_W-1:0] r_sr;
  logic              r_signed;
  logic [CNT_W-1:0]  r_byte_cnt;
  logic [CNT_W-1:0]  r_byte_idx;

  logic [CNT_W-1:0]  w_len;
  logic [PW-1:0]     w_chunk;
  logic [DATA_W-1:0] w_rest;
  logic              w_last;
  logic              w_emit;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_byte_hs;

  // Length is computed from the raw input so it is ready at the accept edge.
  leb128_len_calc #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_len_calc (
    .i_value    (uint_in),
    .i_signed   (signed_encode),
    .o_byte_cnt (w_len)
  );

  // Split the shift register into this byte's payload and the remainder,
  // and decide whether the remainder is fully implied by the payload.
  always_comb begin
    w_chunk = r_sr[PW-1:0];
    if (r_signed) begin
      w_rest = {{PW{r_sr[DATA_W-1]}}, r_sr[DATA_W-1:PW]};
      w_last = ((w_rest == '0) && !w_chunk[PW-1]) ||
               ((w_rest == '1) &&  w_chunk[PW-1]);
    end else begin
      w_rest = {{PW{1'b0}}, r_sr[DATA_W-1:PW]};
      w_last = (w_rest == '0);
    end
  end

  // Handshake qualifiers; a new value may enter on the final-byte handshake.
  always_comb begin
    w_emit     = (r_state == LEB_EMIT);
    w_in_ready = (r_state == LEB_IDLE) | (w_emit & w_last & out_ready);
    w_accept   = in_valid & w_in_ready;
    w_byte_hs  = w_emit & out_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LEB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: stay in EMIT across back-to-back values.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LEB_IDLE: begin
        if (w_accept) begin
          w_state_nxt = LEB_EMIT;
        end
      end
      LEB_EMIT: begin
        if (w_byte_hs && w_last) begin
          w_state_nxt = w_accept ? LEB_EMIT : LEB_IDLE;
        end
      end
      default: begin
        w_state_nxt = LEB_IDLE;
      end
    endcase
  end

  // Datapath: load on accept, advance one payload chunk per non-final byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr       <= '0;
      r_signed   <= 1'b0;
      r_byte_cnt <= '0;
      r_byte_idx <= '0;
    end else if (w_accept) begin
      r_sr       <= uint_in;
      r_signed   <= signed_encode;
      r_byte_cnt <= w_len;
      r_byte_idx <= '0;
    end else if (w_byte_hs && !w_last) begin
      r_sr       <= w_rest;
      r_byte_idx <= r_byte_idx + CNT_W'(1);
    end
  end

  // Outputs: the byte lane is zero outside EMIT so stale data never shows.
  always_comb begin
    in_ready  = w_in_ready;
    out_valid = w_emit;
    out_last  = w_emit & w_last;
    byte_out  = w_emit ? leb128_pack_byte(w_last, w_chunk) : 8'h00;
    byte_cnt  = r_byte_cnt;
    byte_idx  = r_byte_idx;
  end

endmodule : leb128_encode_stream
`default_nettype wire

// File: tb/tb_leb128_encode_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_leb128_encode_stream
//  Description : Self-checking bench for leb128_encode_stream: fixed vectors,
//                randomized values against a reference encoder, stalls,
//                back-to-back transfers and mid-sequence reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_leb128_encode_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] uint_in;
  logic        signed_encode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  byte_out;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [3:0]  byte_cnt;
  logic [3:0]  byte_idx;

  int n_err = 0;
  int n_chk = 0;

  logic [7:0] g_exp [$];

  typedef struct packed {
    logic [63:0] v;
    logic        s;
    logic [3:0]  n;
    logic [79:0] b;   // byte k in b[8k +: 8]
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  leb128_encode_stream dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uint_in       (uint_in),
    .signed_encode (signed_encode),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .byte_out      (byte_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .byte_cnt      (byte_cnt),
    .byte_idx      (byte_idx)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference encoder written straight from the LEB128 definition.
  task automatic model(input logic [63:0] v, input logic s);
    logic [7:0] b;
    logic [63:0] u;
    longint x;
    bit more;
    g_exp.delete();
    if (!s) begin
      u = v;
      more = 1;
      while (more) begin
        b = 8'(u & 64'h7F);
        u = u >> 7;
        more = (u != 0);
        if (more) b = b | 8'h80;
        g_exp.push_back(b);
      end
    end else begin
      x = longint'(v);
      more = 1;
      while (more) begin
        b = 8'(x & 64'h7F);
        x = x >>> 7;
        more = !((x == 0 && b[6] == 1'b0) || (x == -1 && b[6] == 1'b1));
        if (more) b = b | 8'h80;
        g_exp.push_back(b);
      end
    end
  endtask

  // Send one value and collect its bytes; expects to start at posedge+1 in IDLE.
  task automatic run_value(input logic [63:0] v, input logic s, input int stall_pct, input string nm);
    int n;
    int k;
    int cyc;
    n = g_exp.size();
    uint_in = v; signed_encode = s; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({nm, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    uint_in = '0;
    k = 0; cyc = 0;
    while (k < n && cyc < 300) begin
      out_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
      #1;
      if (cyc == 0) chk({nm, ".first_valid"}, 64'(out_valid), 64'd1);
      if (out_valid !== 1'b1) begin
        chk({nm, ".valid_hold"}, 64'(out_valid), 64'd1);
      end else begin
        chk({nm, ".byte"},  64'(byte_out), 64'(g_exp[k]));
        chk({nm, ".idx"},   64'(byte_idx), 64'(k));
        chk({nm, ".cnt"},   64'(byte_cnt), 64'(n));
        chk({nm, ".last"},  64'(out_last), 64'(k == n - 1));
        chk({nm, ".inv"},   64'(out_last), 64'(byte_idx == byte_cnt - 4'd1));
        if (out_ready) k++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    if (cyc >= 300) chk({nm, ".timeout"}, 64'(k), 64'(n));
    out_ready = 1'b1;
    #1;
    chk({nm, ".idle_valid"}, 64'(out_valid), 64'd0);
    chk({nm, ".idle_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rv;
    logic rs;

    tbl[0] = '{64'd624485,               1'b0, 4'd3,  80'h26_8E_E5};
    tbl[1] = '{-64'sd123456,             1'b1, 4'd3,  80'h78_BB_C0};
    tbl[2] = '{64'd64,                   1'b1, 4'd2,  80'h00_C0};
    tbl[3] = '{-64'sd64,                 1'b1, 4'd1,  80'h40};
    tbl[4] = '{64'd0,                    1'b0, 4'd1,  80'h00};
    tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF,  1'b0, 4'd10, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF};
    tbl[6] = '{64'h8000_0000_0000_0000,  1'b1, 4'd10, 80'h7F_80_80_80_80_80_80_80_80_80};
    tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 4'd1,  80'h7F};
    tbl[8] = '{64'd300,                  1'b0, 4'd2,  80'h02_AC};

    rst_n = 1'b0; uint_in = '0; signed_encode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_last",  64'(out_last),  64'd0);
    chk("rst.byte_out",  64'(byte_out),  64'd0);
    chk("rst.byte_cnt",  64'(byte_cnt),  64'd0);
    chk("rst.byte_idx",  64'(byte_idx),  64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fixed vectors with hand-derived bytes.
    for (int t = 0; t < 9; t++) begin
      g_exp.delete();
      for (int j = 0; j < int'(tbl[t].n); j++) g_exp.push_back(tbl[t].b[8*j +: 8]);
      run_value(tbl[t].v, tbl[t].s, 0, $sformatf("vec%0d", t));
    end

    // Heavy stalls on a multi-byte value.
    g_exp.delete();
    g_exp.push_back(8'hE5); g_exp.push_back(8'h8E); g_exp.push_back(8'h26);
    run_value(64'd624485, 1'b0, 60, "stall624485");

    // Randomized values of varied magnitude against the reference encoder.
    for (int r = 0; r < 60; r++) begin
      rv = {$urandom, $urandom} >> $urandom_range(0, 63);
      rs = 1'($urandom_range(0, 1));
      if (rs && $urandom_range(0, 1) == 1) rv = -rv;
      model(rv, rs);
      run_value(rv, rs, (r % 3 == 0) ? 0 : 35, $sformatf("rnd%0d", r));
    end

    // Back-to-back: 1 then 300 with in_valid held, no bubble.
    uint_in = 64'd1; signed_encode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    uint_in = 64'd300;
    #1;
    chk("b2b.b0",      64'(byte_out),  64'h01);
    chk("b2b.b0_last", 64'(out_last),  64'd1);
    chk("b2b.b0_rdy",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("b2b.b1_val",  64'(out_valid), 64'd1);
    chk("b2b.b1",      64'(byte_out),  64'hAC);
    chk("b2b.b1_rdy",  64'(in_ready),  64'd0);
    chk("b2b.b1_idx",  64'(byte_idx),  64'd0);
    chk("b2b.b1_cnt",  64'(byte_cnt),  64'd2);
    @(posedge clk); #2;
    chk("b2b.b2",      64'(byte_out),  64'h02);
    chk("b2b.b2_last", 64'(out_last),  64'd1);
    chk("b2b.b2_rdy",  64'(in_ready),  64'd1);
    @(posedge clk); #2;
    chk("b2b.idle",    64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Reset after the 2nd byte of a 10-byte encode.
    uint_in = 64'hFFFF_FFFF_FFFF_FFFF; signed_encode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("mrst.b0", 64'(byte_out), 64'hFF);
    @(posedge clk); #2;
    chk("mrst.idx1", 64'(byte_idx), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", 64'(out_valid), 64'd0);
    chk("mrst.byte_idx",  64'(byte_idx),  64'd0);
    chk("mrst.byte_cnt",  64'(byte_cnt),  64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mrst.still_idle", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    model(64'd624485, 1'b0);
    run_value(64'd624485, 1'b0, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_leb128_encode_stream
`default_nettype wire
